// File: rtl/uart_result_encoder_pkg.sv
// Shared definitions for the result encoder and the receive-side command translator:
// encoder state set and ASCII byte constants.
package uart_result_encoder_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StSign,
        StDigit,
        StCr,
        StLf
    } state_e;

    localparam logic [7:0] AsciiMinus = 8'h2D;
    localparam logic [7:0] AsciiPlus  = 8'h2B;
    localparam logic [7:0] AsciiZero  = 8'h30;
    localparam logic [7:0] AsciiCr    = 8'h0D;
    localparam logic [7:0] AsciiLf    = 8'h0A;

    function automatic logic [7:0] digit_to_ascii(logic [3:0] d);
        return AsciiZero + {4'h0, d};
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: one binary bit per cycle, MSB first. The load cycle already
// consumes the first bit, so done rises DATA_W-1 cycles after load.
module bin2bcd_serial #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned BCD_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [DATA_W-1:0]       bin,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    done
);

    localparam int unsigned BcdW = 4 * BCD_DIGITS;
    localparam int unsigned CntW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_q;
    logic [BcdW-1:0]   bcd_q;
    logic [BcdW-1:0]   bcd_adj;
    logic [CntW-1:0]   cnt_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            // An all-zero BCD needs no add-3, so the first bit shifts straight in.
            shift_q <= {bin[DATA_W-2:0], 1'b0};
            bcd_q   <= BcdW'(bin[DATA_W-1]);
            cnt_q   <= CntW'(1);
        end else if (!done) begin
            bcd_q   <= {bcd_adj[BcdW-2:0], shift_q[DATA_W-1]};
            shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            cnt_q   <= cnt_q + CntW'(1);
        end
    end

    assign done = (cnt_q == CntW'(DATA_W));
    assign bcd  = bcd_q;

endmodule

// File: rtl/uart_result_encoder.sv
// Prints a signed result as an ASCII decimal frame ('-', digits, CR, LF) over a
// valid/ready byte interface, triggered by a rising edge on start.
module uart_result_encoder
    import uart_result_encoder_pkg::*;
#(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned BCD_DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned DigW = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;

    state_e                  state_q;
    logic                    s1_q;
    logic                    s2_q;
    logic                    start_edge;
    logic                    neg_q;
    logic [DigW-1:0]         dig_q;
    logic [DigW-1:0]         dig_dec;
    logic [DigW-1:0]         top_dig;
    logic [DATA_W-1:0]       mag;
    logic                    load;
    logic                    conv_done;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic [7:0]              top_char;
    logic [7:0]              dec_char;
    logic                    xfer;

    assign start_edge = s1_q & ~s2_q;
    assign load       = (state_q == StIdle) && start_edge;
    // Most negative input wraps to 2^(DATA_W-1), which is still correct as unsigned.
    assign mag        = value[DATA_W-1] ? (~value + DATA_W'(1)) : value;
    assign xfer       = tx_valid & tx_ready;
    assign dig_dec    = dig_q - DigW'(1);

    bin2bcd_serial #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .bin   (mag),
        .bcd   (bcd),
        .done  (conv_done)
    );

    // Highest non-zero digit; falls back to the units digit so zero prints as "0".
    always_comb begin
        top_dig = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                top_dig = DigW'(i);
            end
        end
    end

    assign top_char = digit_to_ascii(bcd[4*top_dig +: 4]);
    assign dec_char = digit_to_ascii(bcd[4*dig_dec +: 4]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            state_q  <= StIdle;
            neg_q    <= 1'b0;
            dig_q    <= '0;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            s1_q <= start;
            s2_q <= s1_q;
            unique case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        neg_q   <= value[DATA_W-1];
                        busy    <= 1'b1;
                        state_q <= StConv;
                    end
                end
                StConv: begin
                    if (conv_done) begin
                        tx_valid <= 1'b1;
                        if (neg_q) begin
                            state_q <= StSign;
                            tx_data <= AsciiMinus;
                        end else begin
                            state_q <= StDigit;
                            dig_q   <= top_dig;
                            tx_data <= top_char;
                        end
                    end
                end
                StSign: begin
                    if (xfer) begin
                        state_q <= StDigit;
                        dig_q   <= top_dig;
                        tx_data <= top_char;
                    end
                end
                StDigit: begin
                    if (xfer) begin
                        if (dig_q == '0) begin
                            state_q <= StCr;
                            tx_data <= AsciiCr;
                        end else begin
                            dig_q   <= dig_dec;
                            tx_data <= dec_char;
                        end
                    end
                end
                StCr: begin
                    if (xfer) begin
                        state_q <= StLf;
                        tx_data <= AsciiLf;
                    end
                end
                StLf: begin
                    if (xfer) begin
                        state_q  <= StIdle;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        tx_data  <= 8'h00;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_encoder.sv
// Directed and random frames checked against a decimal-string model of the printed result.
module tb_uart_result_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] value;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    uart_result_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame from plain integer arithmetic on the signed value.
    task automatic model(input logic [11:0] v);
        int s;
        int m;
        logic [7:0] digs[$];
        s = int'($signed(v));
        exp_q.delete();
        if (s < 0) begin
            exp_q.push_back(8'h2D);
            m = -s;
        end else begin
            m = s;
        end
        do begin
            digs.push_front(8'(8'h30 + m % 10));
            m = m / 10;
        end while (m > 0);
        foreach (digs[i]) exp_q.push_back(digs[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Follows one frame from the edge that first samples start high (index 0).
    task automatic collect(input int rdy_pct, input bit pulse2, input int rst_after);
        int   first = -1;
        int   lf_idx = -1;
        bit   stall = 0;
        bit   done = 0;
        int   ntx = 0;
        int   extra = 0;
        logic [7:0] held = 8'h00;
        got_q.delete();
        @(posedge clk);
        for (int idx = 0; idx < 200 && !done; idx++) begin
            @(negedge clk);
            if (stall) begin
                check("hold_valid", 32'(tx_valid), 1);
                check("hold_data", 32'(tx_data), 32'(held));
            end
            if (idx >= 1) check("busy_in_frame", 32'(busy), 1);
            if (tx_valid === 1'b1 && first < 0) first = idx;
            stall = (tx_valid === 1'b1) && !tx_ready;
            held  = tx_data;
            if (tx_valid === 1'b1 && tx_ready) begin
                got_q.push_back(tx_data);
                ntx++;
                if (tx_data == 8'h0A) begin
                    done   = 1;
                    lf_idx = idx;
                end
            end
            if (idx == 3) start = 1'b0;
            if (pulse2 && idx == 6) start = 1'b1;
            if (pulse2 && idx == 8) start = 1'b0;
            if (rst_after > 0 && ntx == rst_after && tx_valid === 1'b1 && tx_ready) begin
                @(posedge clk);
                #1 rst_n = 1'b0;
                #1;
                check("rst_valid", 32'(tx_valid), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_data", 32'(tx_data), 0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                done = 1;
            end else begin
                @(posedge clk);
                #1 tx_ready = ($urandom_range(99) < rdy_pct);
            end
        end
        check("frame_seen", 32'(done), 1);
        check("latency", 32'(first), 13);
        if (rst_after == 0) begin
            if (rdy_pct == 100) check("back_to_back", 32'(lf_idx - first), 32'(exp_q.size() - 1));
            @(negedge clk);
            check("busy_after", 32'(busy), 0);
            check("valid_after", 32'(tx_valid), 0);
        end
        repeat (30) begin
            @(negedge clk);
            if (tx_valid !== 1'b0) extra++;
        end
        check("quiet_after", 32'(extra), 0);
        check("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic frame(input logic [11:0] v, input int rdy_pct, input bit pulse2,
                         input int rst_after);
        model(v);
        if (rst_after > 0) exp_q = exp_q[0:rst_after-1];
        @(posedge clk);
        #1;
        value    = v;
        start    = 1'b1;
        tx_ready = 1'b1;
        collect(rdy_pct, pulse2, rst_after);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        value    = '0;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(tx_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_data", 32'(tx_data), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        frame(12'h000, 100, 0, 0);
        frame(12'd2047, 100, 0, 0);
        frame(12'h800, 100, 0, 0);
        frame(12'hFF9, 50, 0, 0);
        frame(12'h005, 100, 1, 0);
        frame(12'd1234, 100, 0, 2);
        frame(12'd1234, 100, 0, 0);

        repeat (8) frame(12'($urandom), 50, 0, 0);

        // start already high when reset releases must still launch a frame
        @(posedge clk);
        #1;
        value = 12'($urandom);
        model(value);
        start = 1'b1;
        rst_n = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        collect(100, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
